// File: rtl/conv_pkg.sv
// conv_pkg: shared state type and arithmetic helpers for conv2_stream
package conv_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} conv_state_t;
  function automatic int acc_width(input int w, input int k);
    return 2 * w + $clog2(k * k);
  endfunction
  function automatic int out_w(input int img_w, input int k, input int s);
    return (img_w - k) / s + 1;
  endfunction
  function automatic int out_h(input int img_h, input int k, input int s);
    return (img_h - k) / s + 1;
  endfunction
  // arithmetic shift (floor) then clamp to a signed w-bit range
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] acc, input int frac, input int w);
    logic signed [63:0] sh, hi, lo;
    sh = acc >>> frac;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return sh > hi ? hi : sh < lo ? lo : sh;
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one DEPTH-pixel delay row, advancing only when en is high
module conv_line_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH_BIT = 16
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 en,
  input  logic [WIDTH_BIT-1:0] din,
  output logic [WIDTH_BIT-1:0] dout
);
  logic [DEPTH-1:0][WIDTH_BIT-1:0] sr;
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) sr <= '0;
    else if (en) sr <= {sr[DEPTH-2:0], din};
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/conv2_stream.sv
// conv2_stream: streaming KSIZE x KSIZE valid convolution with stride, scaling, saturation and ReLU
module conv2_stream
  import conv_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int IMG_H = 320,
  parameter int KSIZE = 3,
  parameter int WIDTH_BIT = 16,
  parameter int FRAC_BITS = 0,
  parameter int STRIDE = 1
) (
  input  logic                             clock,
  input  logic                             nreset,
  input  logic                             ker_wr,
  input  logic [$clog2(KSIZE*KSIZE)-1:0]   ker_addr,
  input  logic [WIDTH_BIT-1:0]             ker_data,
  input  logic                             relu_en,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH_BIT-1:0]             in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH_BIT-1:0]             out_data,
  output logic                             busy,
  output logic                             done
);
  localparam int KK = KSIZE * KSIZE;
  localparam int AW = acc_width(WIDTH_BIT, KSIZE);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  conv_state_t state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic relu_q, accept, last_px, win_ok, emit, go;
  logic [KK-1:0][WIDTH_BIT-1:0] ker;
  logic [KSIZE-1:0][WIDTH_BIT-1:0] taps;
  logic [KSIZE-1:0][KSIZE-1:0][WIDTH_BIT-1:0] win, nw;
  logic signed [2*WIDTH_BIT-1:0] prod;
  logic signed [AW-1:0] acc;
  logic [WIDTH_BIT-1:0] sat;
  assign go = state == IDLE && start;
  assign in_ready = state == STREAM && (!out_valid || out_ready);
  assign done = state == FLUSH && (!out_valid || out_ready);
  assign busy = state != IDLE;
  assign accept = in_valid && in_ready;
  assign last_px = row == RW'(IMG_H - 1) && col == CW'(IMG_W - 1);
  assign win_ok = row >= RW'(KSIZE - 1) && col >= CW'(KSIZE - 1) &&
                  (STRIDE == 1 || (row[0] == 1'((KSIZE - 1) % 2) && col[0] == 1'((KSIZE - 1) % 2)));
  assign emit = accept && win_ok;
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = go ? STREAM : (state == STREAM && accept && last_px) ? FLUSH : done ? IDLE : state;
  end
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      row <= '0;
      col <= '0;
      relu_q <= 1'b0;
    end else if (go) begin
      row <= '0;
      col <= '0;
      relu_q <= relu_en;
    end else if (accept) begin
      col <= (col == CW'(IMG_W - 1)) ? '0 : col + 1'b1;
      row <= (col == CW'(IMG_W - 1)) ? row + 1'b1 : row;
    end
  // coefficients are frozen for the whole frame
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) ker <= '0;
    else if (state == IDLE && ker_wr && 32'(ker_addr) < KK) ker[ker_addr] <= ker_data;
  assign taps[0] = in_data;
  for (genvar g = 1; g < KSIZE; g++) begin : g_lb
    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH_BIT(WIDTH_BIT)) u_lb (
      .clock  (clock),
      .nreset (nreset),
      .en     (accept),
      .din    (taps[g-1]),
      .dout   (taps[g])
    );
  end
  // taps[0] is the current row, taps[KSIZE-1] the oldest; the newest column enters at the top index
  always_comb begin
    nw = '0;
    for (int r = 0; r < KSIZE; r++) nw[r] = {taps[r], win[r][KSIZE-1:1]};
  end
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) win <= '0;
    else if (accept) win <= nw;
  always_comb begin
    acc = '0;
    prod = '0;
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE; j++) begin
        prod = (2*WIDTH_BIT)'($signed(nw[KSIZE-1-i][j])) * (2*WIDTH_BIT)'($signed(ker[i*KSIZE+j]));
        acc = acc + AW'(prod);
      end
    sat = WIDTH_BIT'(sat_trunc(64'(acc), FRAC_BITS, WIDTH_BIT));
  end
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data <= (relu_q && sat[WIDTH_BIT-1]) ? '0 : sat;
    end else if (out_ready) out_valid <= 1'b0;
endmodule
